// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron weight-table training sequencer.
// Resolution fields use fixed maximum widths; the top packs narrower fields into the low bits.
package perceptron_pkg;

  localparam int IDX_W_MAX  = 10;
  localparam int HIST_W_MAX = 32;
  localparam int Y_W_MAX    = 32;

  typedef struct packed {
    logic [IDX_W_MAX-1:0]  idx;
    logic [HIST_W_MAX-1:0] history;
    logic                  taken;
    logic                  pred_taken;
    logic [Y_W_MAX-1:0]    y;
  } res_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ADJUST = 2'd2,
    WRITE  = 2'd3
  } train_state_e;

  // floor(1.93*h + 14) in integer arithmetic.
  function automatic int theta(input int history_size);
    return (32'sd193 * history_size + 32'sd1400) / 32'sd100;
  endfunction

  function automatic int sat_add(input int w, input int step, input int width);
    int sum;
    int hi;
    int lo;
    sum = w + step;
    hi  = (32'sd1 <<< (width - 32'sd1)) - 32'sd1;
    lo  = -(32'sd1 <<< (width - 32'sd1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/perceptron_train_ctrl_if.sv
// Branch-resolution handshake from the execute stage into the training sequencer.
interface perceptron_train_ctrl_if #(
  parameter int PERCEPTRON_NUMBER = 64,
  parameter int HISTORY_SIZE      = 8,
  parameter int Y_WIDTH           = 16
);
  localparam int IDX_W = $clog2(PERCEPTRON_NUMBER);

  logic                      res_valid;
  logic                      res_ready;
  logic [IDX_W-1:0]          res_idx;
  logic [HISTORY_SIZE-1:0]   res_history;
  logic                      res_taken;
  logic                      res_pred_taken;
  logic signed [Y_WIDTH-1:0] res_y;

  modport master (
    output res_valid, res_idx, res_history, res_taken, res_pred_taken, res_y,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_idx, res_history, res_taken, res_pred_taken, res_y,
    output res_ready
  );
endinterface

// File: rtl/perceptron_res_fifo.sv
// Resolution queue: synchronous FIFO, no fall-through, pointers carry an extra wrap bit.
module perceptron_res_fifo
  import perceptron_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  res_t din,
  output res_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  res_t        mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Perceptron weight-table training sequencer: queue resolutions, load row, adjust weights, write back.
// Optional PERCEPTRON_TRAIN_STATS_EN adds stat_trained / stat_skipped event counters.
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int  PERCEPTRON_NUMBER = 64,
  parameter int  HISTORY_SIZE      = 8,
  parameter int  WEIGHT_NUMBER     = HISTORY_SIZE + 1,
  parameter int  WIDTH             = 8,
  parameter int  Y_WIDTH           = 16,
  parameter int  THETA             = theta(HISTORY_SIZE),
  parameter int  FIFO_DEPTH        = 4,
  localparam int IDX_W             = $clog2(PERCEPTRON_NUMBER),
  localparam int ROW_W             = WEIGHT_NUMBER * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  perceptron_train_ctrl_if.slave res,
  output logic [IDX_W-1:0]      tbl_rd_idx,
  input  logic [ROW_W-1:0]      tbl_rd_row,
  output logic                  tbl_wr_en,
  output logic [IDX_W-1:0]      tbl_wr_idx,
  output logic [ROW_W-1:0]      tbl_wr_row,
  output logic                  busy
`ifdef PERCEPTRON_TRAIN_STATS_EN
  ,
  output logic [31:0]           stat_trained,
  output logic [31:0]           stat_skipped
`endif
);
  localparam int KW = $clog2(WEIGHT_NUMBER);

  train_state_e              state_r;
  train_state_e              state_next_s;
  res_t                      push_data_s;
  res_t                      head_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      pop_s;
  logic                      train_s;
  logic signed [Y_WIDTH-1:0] head_y_s;
  logic [Y_WIDTH:0]          y_abs_s;
  logic [IDX_W-1:0]          idx_r;
  logic [HISTORY_SIZE-1:0]   hist_r;
  logic                      taken_r;
  logic [ROW_W-1:0]          row_r;
  logic [ROW_W-1:0]          row_adj_s;
  logic [KW-1:0]             k_r;
  logic [WEIGHT_NUMBER-1:0]  x_vec_s;
  logic signed [WIDTH-1:0]   w_cur_s;
  int                        step_s;
  logic                      wr_en_r;
  logic [IDX_W-1:0]          wr_idx_r;
  logic [ROW_W-1:0]          wr_row_r;
  logic                      unused_s;

  always_comb begin
    push_data_s                         = '0;
    push_data_s.idx[IDX_W-1:0]          = res.res_idx;
    push_data_s.history[HISTORY_SIZE-1:0] = res.res_history;
    push_data_s.taken                   = res.res_taken;
    push_data_s.pred_taken              = res.res_pred_taken;
    push_data_s.y[Y_WIDTH-1:0]          = res.res_y;
  end

  perceptron_res_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res.res_valid),
    .pop   (pop_s),
    .din   (push_data_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign res.res_ready = !fifo_full_s;
  assign unused_s      = ^{head_s.idx, head_s.history, head_s.y};

  // |y| is widened by one bit so the most negative y has a representable magnitude.
  always_comb begin
    head_y_s = head_s.y[Y_WIDTH-1:0];
    if (head_y_s[Y_WIDTH-1]) begin
      y_abs_s = ~{head_y_s[Y_WIDTH-1], head_y_s} + (Y_WIDTH+1)'(1);
    end else begin
      y_abs_s = {head_y_s[Y_WIDTH-1], head_y_s};
    end
    train_s = (head_s.taken != head_s.pred_taken) || (y_abs_s <= (Y_WIDTH+1)'(THETA));
  end

  always_comb begin
    x_vec_s   = {hist_r, 1'b1};
    w_cur_s   = row_r[k_r*WIDTH +: WIDTH];
    step_s    = (x_vec_s[k_r] == taken_r) ? 32'sd1 : -32'sd1;
    row_adj_s = row_r;
    row_adj_s[k_r*WIDTH +: WIDTH] = WIDTH'(sat_add(int'(w_cur_s), step_s, WIDTH));
  end

  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s = 1'b1;
          if (train_s) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD:   state_next_s = ADJUST;
      ADJUST: begin
        if (k_r == KW'(WEIGHT_NUMBER - 1)) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = ADJUST;
        end
      end
      WRITE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // The write strobe and row are registered on the final ADJUST edge so WRITE drives them glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      hist_r   <= '0;
      taken_r  <= 1'b0;
      row_r    <= '0;
      k_r      <= '0;
      wr_en_r  <= 1'b0;
      wr_idx_r <= '0;
      wr_row_r <= '0;
    end else begin
      state_r <= state_next_s;
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s && train_s) begin
            idx_r   <= head_s.idx[IDX_W-1:0];
            hist_r  <= head_s.history[HISTORY_SIZE-1:0];
            taken_r <= head_s.taken;
          end
        end
        LOAD: begin
          row_r <= tbl_rd_row;
          k_r   <= '0;
        end
        ADJUST: begin
          row_r <= row_adj_s;
          k_r   <= k_r + KW'(1);
          if (state_next_s == WRITE) begin
            wr_en_r  <= 1'b1;
            wr_idx_r <= idx_r;
            wr_row_r <= row_adj_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign tbl_rd_idx = idx_r;
  assign tbl_wr_en  = wr_en_r;
  assign tbl_wr_idx = wr_idx_r;
  assign tbl_wr_row = wr_row_r;
  assign busy       = (state_r != IDLE) || !fifo_empty_s;

`ifdef PERCEPTRON_TRAIN_STATS_EN
  logic [31:0] trained_r;
  logic [31:0] skipped_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trained_r <= 32'd0;
      skipped_r <= 32'd0;
    end else begin
      if (state_r == WRITE) begin
        trained_r <= trained_r + 32'd1;
      end
      if (pop_s && !train_s) begin
        skipped_r <= skipped_r + 32'd1;
      end
    end
  end

  assign stat_trained = trained_r;
  assign stat_skipped = skipped_r;
`endif

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Scoreboard bench for perceptron_train_ctrl: a bench-side weight table and an independent
// training model predict every table write; the monitor compares each write in order.
module tb_perceptron_train_ctrl;
  localparam int PN = 8;
  localparam int HS = 4;
  localparam int WN = 5;
  localparam int WD = 8;
  localparam int YW = 16;
  localparam int TH = 20;
  localparam int FD = 4;
  localparam int IW = 3;
  localparam int RW = WN * WD;

  typedef struct {
    logic [IW-1:0] idx;
    logic [RW-1:0] row;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] tbl_rd_idx;
  logic [RW-1:0] tbl_rd_row;
  logic          tbl_wr_en;
  logic [IW-1:0] tbl_wr_idx;
  logic [RW-1:0] tbl_wr_row;
  logic          busy;
`ifdef PERCEPTRON_TRAIN_STATS_EN
  logic [31:0]   stat_trained;
  logic [31:0]   stat_skipped;
`endif

  logic [RW-1:0] tbl [PN];
  logic [RW-1:0] shadow [PN];
  logic [RW-1:0] shadow_save [PN];
  logic          pre_en = 1'b0;
  logic [IW-1:0] pre_idx = '0;
  logic [RW-1:0] pre_row = '0;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   n_writes = 0;
  int   cyc = 0;
  int   push_cyc = 0;
  logic saw_not_ready = 1'b0;

  perceptron_train_ctrl_if #(.PERCEPTRON_NUMBER(PN), .HISTORY_SIZE(HS), .Y_WIDTH(YW)) rif ();

  perceptron_train_ctrl #(
    .PERCEPTRON_NUMBER (PN),
    .HISTORY_SIZE      (HS),
    .WIDTH             (WD),
    .Y_WIDTH           (YW),
    .THETA             (TH),
    .FIFO_DEPTH        (FD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res        (rif),
    .tbl_rd_idx (tbl_rd_idx),
    .tbl_rd_row (tbl_rd_row),
    .tbl_wr_en  (tbl_wr_en),
    .tbl_wr_idx (tbl_wr_idx),
    .tbl_wr_row (tbl_wr_row),
    .busy       (busy)
`ifdef PERCEPTRON_TRAIN_STATS_EN
    ,
    .stat_trained (stat_trained),
    .stat_skipped (stat_skipped)
`endif
  );

  always #5 clk = ~clk;

  assign tbl_rd_row = tbl[tbl_rd_idx];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pre_en) tbl[pre_idx] = pre_row;
    else if (tbl_wr_en) tbl[tbl_wr_idx] = tbl_wr_row;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] row, input logic [HS-1:0] h,
                                              input logic t);
    logic [RW-1:0]         r;
    logic signed [WD-1:0]  wb;
    int                    w;
    int                    x;
    r = row;
    for (int j = 0; j < WN; j++) begin
      wb = row[j*WD +: WD];
      w  = int'(wb);
      if (j == 0) x = 1;
      else x = h[j-1] ? 1 : -1;
      w = w + (t ? x : -x);
      if (w > 127) w = 127;
      else if (w < -128) w = -128;
      r[j*WD +: WD] = w[WD-1:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tbl_wr_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(tbl_wr_en), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_idx", 64'(tbl_wr_idx), 64'(e.idx));
        check("wr_row", 64'(tbl_wr_row), 64'(e.row));
      end
    end
  end

  task automatic preload(input logic [IW-1:0] idx, input logic [RW-1:0] row);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_row = row;
    shadow[idx] = row;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic push(input logic [IW-1:0] idx, input logic [HS-1:0] h, input logic t,
                      input logic p, input logic signed [YW-1:0] y);
    int   n;
    int   yi;
    exp_t e;
    @(negedge clk);
    rif.res_valid = 1'b1; rif.res_idx = idx; rif.res_history = h;
    rif.res_taken = t; rif.res_pred_taken = p; rif.res_y = y;
    n = 0;
    while (!rif.res_ready && n < 50) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!rif.res_ready) begin
      check("push_timeout", 64'(rif.res_ready), 64'd1);
      rif.res_valid = 1'b0;
      return;
    end
    yi = int'(y);
    if (yi < 0) yi = -yi;
    if ((t != p) || (yi <= TH)) begin
      e.idx = idx;
      e.row = model_row(shadow[idx], h, t);
      shadow[idx] = e.row;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rif.res_valid = 1'b0;
    push_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int wr_before;
    rif.res_valid = 1'b0; rif.res_idx = '0; rif.res_history = '0;
    rif.res_taken = 1'b0; rif.res_pred_taken = 1'b0; rif.res_y = '0;
    for (int i = 0; i < PN; i++) shadow[i] = '0;
    for (int i = 0; i < PN; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = IW'(i); pre_row = '0;
    end
    @(negedge clk);
    pre_en = 1'b0;
    check("rst_wr_en", 64'(tbl_wr_en), 64'd0);
    check("rst_rd_idx", 64'(tbl_rd_idx), 64'd0);
    check("rst_wr_idx", 64'(tbl_wr_idx), 64'd0);
    check("rst_wr_row", 64'(tbl_wr_row), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(rif.res_ready), 64'd1);

    // Single training event on a zero row, with latency from push.
    push(3'd3, 4'b0101, 1'b1, 1'b0, 16'sd0);
    n = 0;
    while (!tbl_wr_en && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("s1_latency", 64'(cyc - push_cyc), 64'd7);
    check("s1_idx", 64'(tbl_wr_idx), 64'd3);
    check("s1_row", 64'(tbl_wr_row), 64'hFF01FF0101);
    wait_idle("s1");

    // Threshold decisions.
    push(3'd2, 4'b0011, 1'b1, 1'b1, 16'sd25);
    @(negedge clk);
    check("s2_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    check("s2_busy_c2", 64'(busy), 64'd0);
    push(3'd2, 4'b0011, 1'b1, 1'b1, 16'sd20);
    push(3'd2, 4'b1001, 1'b0, 1'b0, -16'sd21);
    push(3'd2, 4'b1001, 1'b0, 1'b0, -16'sd20);
    push(3'd4, 4'b1111, 1'b1, 1'b1, -16'sd32768);
    push(3'd4, 4'b1010, 1'b0, 1'b1, 16'sd25);
    wait_idle("s2");

    // Saturation at both weight limits.
    preload(3'd1, {8'hFD, 8'h05, 8'h00, 8'h80, 8'h7F});
    push(3'd1, 4'b1110, 1'b1, 1'b0, 16'sd100);
    wait_idle("s3");
    check("s3_row", 64'(tbl[1]), 64'hFE0601807F);

    // Back-to-back pushes filling the queue.
    saw_not_ready = 1'b0;
    wr_before = n_writes;
    push(3'd0, 4'b0001, 1'b1, 1'b0, 16'sd0);
    push(3'd2, 4'b0010, 1'b0, 1'b1, 16'sd3);
    push(3'd4, 4'b0100, 1'b1, 1'b1, -16'sd5);
    push(3'd6, 4'b1000, 1'b0, 1'b0, 16'sd7);
    push(3'd7, 4'b1111, 1'b1, 1'b0, 16'sd30);
    push(3'd0, 4'b0110, 1'b0, 1'b1, -16'sd30);
    wait_idle("s4");
    check("s4_writes", 64'(n_writes - wr_before), 64'd6);
    check("s4_backpressure", 64'(saw_not_ready), 64'd1);

    // Reset during ADJUST abandons the active and queued events.
    shadow_save = shadow;
    push(3'd5, 4'b0101, 1'b1, 1'b0, 16'sd0);
    push(3'd6, 4'b0011, 1'b0, 1'b1, 16'sd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    shadow = shadow_save;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_ready", 64'(rif.res_ready), 64'd1);
    check("s5_busy", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    check("s5_row5", 64'(tbl[5]), 64'(shadow[5]));
    check("s5_row6", 64'(tbl[6]), 64'(shadow[6]));

    // Same row trained twice in a row reads the first write back.
    push(3'd5, 4'b0101, 1'b1, 1'b0, 16'sd0);
    push(3'd5, 4'b0101, 1'b1, 1'b0, 16'sd0);
    wait_idle("s6");
    check("s6_row", 64'(tbl[5]), 64'hFE02FE0202);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
